tdm_demux_4t1: RTL and testbench

TDM_DEMUX_4T1 -- requirements
Module: tdm_demux_4t1

---
 rtl/tdm_demux_4t1.sv | 83 ++++++++
 tb/tb_tdm_demux_4t1.sv | 128 ++++++++++++
 2 files changed

// File: rtl/tdm_demux_4t1.sv
// tdm_demux_4t1: 4-channel TDM serial demultiplexer with Sync-framed slots.
// Define TDM_DEMUX_PARITY_EN to add a fifth even-parity slot that gates the output update.
module tdm_demux_4t1 (
  input  logic       clk,
  input  logic       rst,
  input  logic       F,
  input  logic       Sync,
  output logic       A,
  output logic       B,
  output logic       C,
  output logic       D,
  output logic [1:0] Sel,
  output logic       Valid,
  output logic       Err
);
`ifdef TDM_DEMUX_PARITY_EN
  localparam int CW = 3;
  localparam int NS = 5;
`else
  localparam int CW = 2;
  localparam int NS = 4;
`endif
  localparam logic [CW-1:0] LAST = CW'(NS - 1);
  typedef enum logic {IDLE, RECV} state_t;
  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [NS-1:0]   sh_q, sh_d;
  logic [3:0]      out_q, out_d;
  logic            valid_q, valid_d, err_q, err_d;
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sh_d    = sh_q;
    out_d   = out_q;
    valid_d = 1'b0;
    err_d   = 1'b0;
    if (Sync) begin
      sh_d[0] = F;
      cnt_d   = CW'(1);
      state_d = RECV;
    end else if (state_q == RECV) begin
      sh_d[cnt_q] = F;
      if (cnt_q == LAST) begin
        state_d = IDLE;
        cnt_d   = '0;
`ifdef TDM_DEMUX_PARITY_EN
        if (^sh_d == 1'b0) begin
          out_d   = sh_d[3:0];
          valid_d = 1'b1;
        end else begin
          err_d = 1'b1;
        end
`else
        out_d   = sh_d;
        valid_d = 1'b1;
`endif
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      sh_q    <= '0;
      out_q   <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sh_q    <= sh_d;
      out_q   <= out_d;
      valid_q <= valid_d;
      err_q   <= err_d;
    end
  end
  assign {D, C, B, A} = out_q;
  assign Sel   = (state_q == RECV) ? cnt_q[1:0] : 2'b00;
  assign Valid = valid_q;
  assign Err   = err_q;
endmodule

// File: tb/tb_tdm_demux_4t1.sv
// tb_tdm_demux_4t1: scoreboard bench; a frame-level model pushes expected results, a monitor pops them.
module tb_tdm_demux_4t1;
`ifdef TDM_DEMUX_PARITY_EN
  localparam int NS = 5;
`else
  localparam int NS = 4;
`endif
  logic clk = 1'b0, rst = 1'b1, F = 1'b0, Sync = 1'b0;
  logic A, B, C, D, Valid, Err;
  logic [1:0] Sel;
  int n_chk = 0, n_fail = 0;
  typedef struct {logic err; logic [3:0] out;} exp_t;
  exp_t sb[$];
  bit fr[$];
  bit act = 1'b0;
  logic [3:0] mon_out = 4'h0;

  tdm_demux_4t1 dut (.clk(clk), .rst(rst), .F(F), .Sync(Sync), .A(A), .B(B), .C(C), .D(D),
                     .Sel(Sel), .Valid(Valid), .Err(Err));

  always #5 clk = ~clk;

  function automatic void chk(input string name, input int actual, input int expected);
    n_chk++;
    if (actual != expected) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, actual, expected);
    end
  endfunction

  // Drives one slot for the coming edge; the model works on whole frames collected as a bit list.
  task automatic step(input bit s_i, input bit f_i);
    exp_t e;
    bit par;
    Sync = s_i;
    F = f_i;
    chk("sel", int'(Sel), act ? (fr.size() % 4) : 0);
    if (s_i) begin
      fr.delete();
      fr.push_back(f_i);
      act = 1'b1;
    end else if (act) begin
      fr.push_back(f_i);
    end
    if (act && fr.size() == NS) begin
      par = 1'b0;
      foreach (fr[i]) par ^= fr[i];
      e.out = {fr[3], fr[2], fr[1], fr[0]};
      e.err = (NS == 5) && par;
      sb.push_back(e);
      act = 1'b0;
    end
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    Sync = 1'b0;
    act = 1'b0;
    fr.delete();
    sb.delete();
    repeat (2) @(posedge clk);
    #2;
    rst = 1'b0;
  endtask

  task automatic frame(input logic [3:0] bits);
    for (int i = 0; i < 4; i++) step(i == 0, bits[3 - i]);
`ifdef TDM_DEMUX_PARITY_EN
    step(1'b0, ^bits);
`endif
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      mon_out = 4'h0;
      chk("reset_out", int'({D, C, B, A}), 0);
      chk("reset_valid", int'({Valid, Err}), 0);
    end else begin
      if (Valid || Err) begin
        if (sb.size() == 0) begin
          chk("unexpected_pulse", int'({Valid, Err}), 0);
        end else begin
          e = sb.pop_front();
          chk("pulse_kind", int'({Valid, Err}), e.err ? 1 : 2);
          if (!e.err) mon_out = e.out;
        end
      end
      chk("outputs", int'({A, B, C, D}), int'({mon_out[0], mon_out[1], mon_out[2], mon_out[3]}));
    end
  end

  initial begin
    repeat (2) @(posedge clk);
    #2;
    rst = 1'b0;
    for (int i = 0; i < 10; i++) step(1'b0, i[0]);
    frame(4'b0101);
    frame(4'b1100);
    frame(4'b0011);
    step(1'b1, 1'b1);
    step(1'b0, 1'b0);
    frame(4'b1111);
    step(1'b0, 1'b0);
    step(1'b1, 1'b1);
    step(1'b0, 1'b0);
    do_reset();
    step(1'b0, 1'b1);
    step(1'b0, 1'b0);
    frame(4'b1010);
    step(1'b0, 1'b0);
`ifdef TDM_DEMUX_PARITY_EN
    for (int i = 0; i < 4; i++) step(i == 0, i != 1);
    step(1'b0, 1'b1);
    for (int i = 0; i < 4; i++) step(i == 0, i != 1);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
`endif
    for (int i = 0; i < 400; i++) step($urandom_range(0, 5) == 0, 1'($urandom));
    step(1'b0, 1'b0);
    for (int i = 0; i < 6; i++) step(1'b0, 1'b0);
    chk("scoreboard_empty", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
